// File: rtl/arith_result_fifo_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : arith_result_fifo_if
// Brief    : Result push / head pop / statistics bundle for arith_result_fifo.
// Revision : 1.0
//------------------------------------------------------------------------------
interface arith_result_fifo_if #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
);
   logic                     in_valid;
   logic                     in_ready;
   logic [8:0]               sumab;
   logic                     sumflag;
   logic [7:0]               leftshiftA;
   logic                     lessflag;
   logic                     equalflag;
   logic                     bitXorflag;
   logic                     out_valid;
   logic                     out_ready;
   logic [8:0]               out_sum;
   logic [7:0]               out_shift;
   logic [3:0]               out_flags;
   logic [$clog2(DEPTH):0]   level;
   logic [15:0]              acc;
   logic                     acc_wrap;
   logic [CNT_W-1:0]         less_cnt;
   logic [CNT_W-1:0]         equal_cnt;
   logic [CNT_W-1:0]         carry_cnt;
   logic                     stat_clr;

   modport slave (
      input  in_valid, sumab, sumflag, leftshiftA, lessflag, equalflag,
             bitXorflag, out_ready, stat_clr,
      output in_ready, out_valid, out_sum, out_shift, out_flags, level,
             acc, acc_wrap, less_cnt, equal_cnt, carry_cnt
   );

   modport master (
      output in_valid, sumab, sumflag, leftshiftA, lessflag, equalflag,
             bitXorflag, out_ready, stat_clr,
      input  in_ready, out_valid, out_sum, out_shift, out_flags, level,
             acc, acc_wrap, less_cnt, equal_cnt, carry_cnt
   );
endinterface
`default_nettype wire

// File: rtl/arith_result_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : arith_result_fifo
// Brief    : FWFT result FIFO behind SimpleArithmetic with running statistics.
// Revision : 1.0
//------------------------------------------------------------------------------
module arith_result_fifo #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  wire logic            clk,
   input  wire logic            rst,
   arith_result_fifo_if.slave   bus
);
   localparam int c_AW = $clog2(DEPTH);
   localparam int c_PW = c_AW + 1;

   logic [c_PW-1:0]  r_wr_ptr;
   logic [c_PW-1:0]  r_rd_ptr;
   logic [20:0]      r_mem [DEPTH];
   logic [15:0]      r_acc;
   logic             r_acc_wrap;
   logic [CNT_W-1:0] r_less_cnt;
   logic [CNT_W-1:0] r_equal_cnt;
   logic [CNT_W-1:0] r_carry_cnt;

   logic [c_PW-1:0]  w_level;
   logic             w_in_ready;
   logic             w_out_valid;
   logic             w_push;
   logic             w_pop;
   logic [20:0]      w_entry;
   logic [20:0]      w_head;
   logic [16:0]      w_acc_sum;

   // Pointer MSB separates full from empty, so the difference is the occupancy.
   assign w_level     = r_wr_ptr - r_rd_ptr;
   assign w_in_ready  = (w_level != c_PW'(DEPTH));
   assign w_out_valid = (w_level != '0);
   assign w_push      = bus.in_valid & w_in_ready;
   assign w_pop       = bus.out_ready & w_out_valid;

   assign w_entry = {bus.sumab, bus.leftshiftA,
                     bus.sumflag, bus.lessflag, bus.equalflag, bus.bitXorflag};
   assign w_head  = r_mem[r_rd_ptr[c_AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: entries are only visible between the pointers.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= w_entry;
   end

   assign w_acc_sum = {1'b0, r_acc} + 17'(bus.sumab);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc       <= '0;
         r_acc_wrap  <= 1'b0;
         r_less_cnt  <= '0;
         r_equal_cnt <= '0;
         r_carry_cnt <= '0;
      end else if (bus.stat_clr) begin
         // Clear takes priority over a push in the same cycle.
         r_acc       <= '0;
         r_acc_wrap  <= 1'b0;
         r_less_cnt  <= '0;
         r_equal_cnt <= '0;
         r_carry_cnt <= '0;
      end else if (w_push) begin
         r_acc <= w_acc_sum[15:0];
         if (w_acc_sum[16]) r_acc_wrap <= 1'b1;
         if (bus.lessflag  && (r_less_cnt  != '1)) r_less_cnt  <= r_less_cnt  + 1'b1;
         if (bus.equalflag && (r_equal_cnt != '1)) r_equal_cnt <= r_equal_cnt + 1'b1;
         if (bus.sumflag   && (r_carry_cnt != '1)) r_carry_cnt <= r_carry_cnt + 1'b1;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_sum   = w_out_valid ? w_head[20:12] : '0;
   assign bus.out_shift = w_out_valid ? w_head[11:4]  : '0;
   assign bus.out_flags = w_out_valid ? w_head[3:0]   : '0;
   assign bus.level     = w_level;
   assign bus.acc       = r_acc;
   assign bus.acc_wrap  = r_acc_wrap;
   assign bus.less_cnt  = r_less_cnt;
   assign bus.equal_cnt = r_equal_cnt;
   assign bus.carry_cnt = r_carry_cnt;
endmodule
`default_nettype wire

// File: tb/tb_arith_result_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_arith_result_fifo
// Brief    : Self-checking bench for arith_result_fifo against a queue model.
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_arith_result_fifo;
   localparam int DEPTH = 4;
   localparam int CNT_W = 8;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;

   logic [20:0] q[$];
   int          m_acc;
   bit          m_wrap;
   int          m_less, m_eq, m_carry;

   arith_result_fifo_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

   arith_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [20:0] exp_head();
      return (q.size() != 0) ? q[0] : 21'd0;
   endfunction

   function automatic logic [20:0] dut_head();
      return {bus.out_sum, bus.out_shift, bus.out_flags};
   endfunction

   // One clock of stimulus; model is advanced from its own occupancy.
   task automatic step(input logic v, input logic [8:0] s, input logic [7:0] sh,
                       input logic [3:0] f, input logic ordy, input logic clr);
      bit m_push, m_pop;
      bus.in_valid   = v;
      bus.sumab      = s;
      bus.leftshiftA = sh;
      bus.sumflag    = f[3];
      bus.lessflag   = f[2];
      bus.equalflag  = f[1];
      bus.bitXorflag = f[0];
      bus.out_ready  = ordy;
      bus.stat_clr   = clr;
      m_push = v && (q.size() < DEPTH);
      m_pop  = ordy && (q.size() > 0);
      @(posedge clk);
      #1;
      if (m_pop)  void'(q.pop_front());
      if (m_push) q.push_back({s, sh, f});
      if (clr) begin
         m_acc = 0; m_wrap = 0; m_less = 0; m_eq = 0; m_carry = 0;
      end else if (m_push) begin
         m_acc = m_acc + int'(s);
         if (m_acc >= 65536) begin
            m_acc  = m_acc - 65536;
            m_wrap = 1;
         end
         if (f[2]) m_less  = (m_less  < CMAX) ? m_less  + 1 : CMAX;
         if (f[1]) m_eq    = (m_eq    < CMAX) ? m_eq    + 1 : CMAX;
         if (f[3]) m_carry = (m_carry < CMAX) ? m_carry + 1 : CMAX;
      end
   endtask

   task automatic idle();
      bus.in_valid = 0; bus.sumab = '0; bus.leftshiftA = '0; bus.sumflag = 0;
      bus.lessflag = 0; bus.equalflag = 0; bus.bitXorflag = 0;
      bus.out_ready = 0; bus.stat_clr = 0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      q.delete();
      m_acc = 0; m_wrap = 0; m_less = 0; m_eq = 0; m_carry = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (bus.level !== 3'd0) $display("FAIL reset_level: got %0d want 0", bus.level);
      else n_pass++;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
         $display("FAIL reset_status: got ov=%b ir=%b want ov=0 ir=1", bus.out_valid, bus.in_ready);
      else n_pass++;
      n_checks++;
      if (dut_head() !== 21'd0) $display("FAIL reset_head: got %h want 0", dut_head());
      else n_pass++;
      n_checks++;
      if (bus.acc !== 16'd0 || bus.acc_wrap !== 1'b0 || bus.less_cnt !== '0 ||
          bus.equal_cnt !== '0 || bus.carry_cnt !== '0)
         $display("FAIL reset_stats: got acc=%0d wrap=%b l=%0d e=%0d c=%0d want all 0",
                  bus.acc, bus.acc_wrap, bus.less_cnt, bus.equal_cnt, bus.carry_cnt);
      else n_pass++;
   endtask

   task automatic test_first_push();
      do_reset();
      bus.in_valid = 1;
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL no_bypass: got ov=%b want 0", bus.out_valid);
      else n_pass++;
      step(1, 9'h1FE, 8'hFE, 4'b1001, 0, 0);
      n_checks++;
      if (bus.out_valid !== 1'b1) $display("FAIL first_valid: got %b want 1", bus.out_valid);
      else n_pass++;
      n_checks++;
      if (bus.out_sum !== 9'd510 || bus.out_shift !== 8'd254 || bus.out_flags !== 4'b1001)
         $display("FAIL first_head: got %0d/%0d/%b want 510/254/1001",
                  bus.out_sum, bus.out_shift, bus.out_flags);
      else n_pass++;
      n_checks++;
      if (bus.acc !== 16'd510 || bus.carry_cnt !== 8'd1)
         $display("FAIL first_stats: got acc=%0d carry=%0d want 510/1", bus.acc, bus.carry_cnt);
      else n_pass++;
   endtask

   task automatic test_fill();
      int exp_acc;
      logic [8:0] s;
      do_reset();
      exp_acc = 0;
      for (int i = 0; i < 5; i++) begin
         s = 9'($urandom_range(1, 511));
         if (i < 4) exp_acc += int'(s);
         step(1, s, 8'($urandom), 4'($urandom), 0, 0);
         if (i == 3) begin
            n_checks++;
            if (bus.in_ready !== 1'b0) $display("FAIL fill_ready: got %b want 0", bus.in_ready);
            else n_pass++;
         end
      end
      n_checks++;
      if (bus.level !== 3'd4) $display("FAIL fill_level: got %0d want 4", bus.level);
      else n_pass++;
      n_checks++;
      if (bus.acc !== 16'(exp_acc)) $display("FAIL fill_acc: got %0d want %0d", bus.acc, 16'(exp_acc));
      else n_pass++;
   endtask

   task automatic test_full_stream();
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if (dut_head() !== exp_head())
            $display("FAIL stream_head%0d: got %h want %h", i, dut_head(), exp_head());
         else n_pass++;
         step(1, 9'($urandom), 8'($urandom), 4'($urandom), 1, 0);
         n_checks++;
         if (bus.level !== 3'd3) $display("FAIL stream_level%0d: got %0d want 3", i, bus.level);
         else n_pass++;
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 1; i <= 300; i++) begin
         step(1, 9'd511, 8'h55, 4'b1100, 1, 0);
         if (i == 128) begin
            n_checks++;
            if (bus.acc_wrap !== 1'b0) $display("FAIL wrap_early: got %b want 0", bus.acc_wrap);
            else n_pass++;
         end
         if (i == 129) begin
            n_checks++;
            if (bus.acc_wrap !== 1'b1 || bus.acc !== 16'd383)
               $display("FAIL wrap_129: got wrap=%b acc=%0d want 1/383", bus.acc_wrap, bus.acc);
            else n_pass++;
            n_checks++;
            if (bus.less_cnt !== 8'd129) $display("FAIL less_129: got %0d want 129", bus.less_cnt);
            else n_pass++;
         end
      end
      n_checks++;
      if (bus.less_cnt !== 8'd255 || bus.carry_cnt !== 8'd255 || bus.equal_cnt !== 8'd0)
         $display("FAIL saturate: got l=%0d c=%0d e=%0d want 255/255/0",
                  bus.less_cnt, bus.carry_cnt, bus.equal_cnt);
      else n_pass++;
      n_checks++;
      if (bus.acc !== 16'(m_acc) || bus.acc_wrap !== m_wrap)
         $display("FAIL sat_acc: got %0d/%b want %0d/%b", bus.acc, bus.acc_wrap, 16'(m_acc), m_wrap);
      else n_pass++;
   endtask

   task automatic test_stat_clr();
      for (int i = 0; i < 3; i++) step(0, '0, '0, '0, 1, 0);
      step(1, 9'd100, 8'h32, 4'b0110, 0, 1);
      n_checks++;
      if (bus.acc !== 16'd0 || bus.acc_wrap !== 1'b0 || bus.less_cnt !== '0 ||
          bus.equal_cnt !== '0 || bus.carry_cnt !== '0)
         $display("FAIL clr_stats: got acc=%0d wrap=%b l=%0d e=%0d c=%0d want all 0",
                  bus.acc, bus.acc_wrap, bus.less_cnt, bus.equal_cnt, bus.carry_cnt);
      else n_pass++;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== 9'd100 || bus.level !== 3'd1)
         $display("FAIL clr_entry: got ov=%b sum=%0d lvl=%0d want 1/100/1",
                  bus.out_valid, bus.out_sum, bus.level);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 3; i++) step(1, 9'($urandom_range(1, 511)), 8'($urandom), 4'($urandom), 0, 0);
      n_checks++;
      if (bus.level !== 3'd3 || bus.acc !== 16'(m_acc))
         $display("FAIL pre_arst: got lvl=%0d acc=%0d want 3/%0d", bus.level, bus.acc, 16'(m_acc));
      else n_pass++;
      #2;
      rst = 1;
      #1;
      n_checks++;
      if (bus.level !== 3'd0 || bus.out_valid !== 1'b0 || bus.acc !== 16'd0 || bus.in_ready !== 1'b1)
         $display("FAIL async_rst: got lvl=%0d ov=%b acc=%0d ir=%b want 0/0/0/1",
                  bus.level, bus.out_valid, bus.acc, bus.in_ready);
      else n_pass++;
      do_reset();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, 9'($urandom), 8'($urandom), 4'($urandom),
              $urandom_range(0, 2) == 0, $urandom_range(0, 31) == 0);
         n_checks++;
         if (bus.level !== 3'(q.size()) || bus.in_ready !== (q.size() < DEPTH) ||
             bus.out_valid !== (q.size() > 0))
            $display("FAIL rnd_status%0d: got lvl=%0d ir=%b ov=%b want lvl=%0d",
                     i, bus.level, bus.in_ready, bus.out_valid, q.size());
         else n_pass++;
         n_checks++;
         if (dut_head() !== exp_head())
            $display("FAIL rnd_head%0d: got %h want %h", i, dut_head(), exp_head());
         else n_pass++;
         n_checks++;
         if (bus.acc !== 16'(m_acc) || bus.acc_wrap !== m_wrap || bus.less_cnt !== 8'(m_less) ||
             bus.equal_cnt !== 8'(m_eq) || bus.carry_cnt !== 8'(m_carry))
            $display("FAIL rnd_stats%0d: got %0d/%b/%0d/%0d/%0d want %0d/%b/%0d/%0d/%0d", i,
                     bus.acc, bus.acc_wrap, bus.less_cnt, bus.equal_cnt, bus.carry_cnt,
                     m_acc, m_wrap, m_less, m_eq, m_carry);
         else n_pass++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst      = 1;
      idle();
      test_reset();
      test_first_push();
      test_fill();
      test_full_stream();
      test_saturation();
      test_stat_clr();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
